free_list: RTL and testbench

Physical-register free list for the R10K rename path. It sits between dispatch/rename, which consumes new PR tags, and retire, which returns each committed instruction's old PR (Told) as a bitmap. On a branch mispredict it takes the retire-side checkpoint bitmap and makes it the whole free list in one step.

---
 rtl/free_list_pkg.sv | 12 +
 rtl/free_list_ps_lowest_n.sv | 36 +++
 rtl/free_list.sv | 89 ++++++++
 tb/tb_free_list.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/free_list_pkg.sv
// Shared rename-path constants: machine width, register file sizes and the
// post-reset free bitmap that the retire checkpoint logic also starts from.
package free_list_pkg;
  localparam int N                = 3;
  localparam int PHYS_REG_SZ_R10K = 64;
  localparam int ARCH_REG_SZ      = 32;
  localparam int PHYS_TAG         = $clog2(PHYS_REG_SZ_R10K);

  // PR0..ARCH_REG_SZ-1 hold the initial architectural mapping, so they start busy.
  localparam logic [PHYS_REG_SZ_R10K-1:0] INITIAL_AVAIL_MASK =
    {{(PHYS_REG_SZ_R10K-ARCH_REG_SZ){1'b1}}, {ARCH_REG_SZ{1'b0}}};
endpackage

// File: rtl/free_list_ps_lowest_n.sv
// Multi-grant priority selector: returns the N lowest set bits of req, each as
// an index, a one-hot vector and a valid flag. Slot validity is monotonic.
module free_list_ps_lowest_n #(
  parameter  int W  = 64,
  parameter  int N  = 3,
  localparam int IW = $clog2(W)
) (
  input  logic [W-1:0]    req,
  output logic [N-1:0]    sel_valid,
  output logic [N*IW-1:0] sel_idx,
  output logic [N*W-1:0]  sel_onehot
);

  always_comb begin
    logic [W-1:0] rem;
    logic [W-1:0] hit;
    rem        = req;
    hit        = '0;
    sel_valid  = '0;
    sel_idx    = '0;
    sel_onehot = '0;
    for (int k = 0; k < N; k++) begin
      hit = '0;
      for (int i = 0; i < W; i++) begin
        if (rem[i] && (hit == '0)) begin
          hit[i]            = 1'b1;
          sel_idx[k*IW +: IW] = IW'(i);
        end
      end
      sel_valid[k]          = |hit;
      sel_onehot[k*W +: W]  = hit;
      rem                   = rem & ~hit;
    end
  end

endmodule

// File: rtl/free_list.sv
// R10K physical-register free list: zero-latency in-order multi-lane allocation,
// bitmap frees from retire, and single-cycle restore on mispredict.
module free_list #(
  parameter  int N          = free_list_pkg::N,
  parameter  int PHYS_REGS  = free_list_pkg::PHYS_REG_SZ_R10K,
  parameter  int ARCH_COUNT = free_list_pkg::ARCH_REG_SZ,
  localparam int PRW        = $clog2(PHYS_REGS),
  localparam int CNTW       = $clog2(PHYS_REGS+1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         alloc_req,
  output logic [N-1:0]         alloc_valid,
  output logic [N*PRW-1:0]     alloc_tags,
  input  logic [PHYS_REGS-1:0] free_mask,
  input  logic                 mispredict,
  input  logic [PHYS_REGS-1:0] restore_mask,
  output logic [CNTW-1:0]      free_count,
  output logic [PHYS_REGS-1:0] avail_dbg,
  output logic                 double_free_err
);
  import free_list_pkg::*;

  localparam logic [PHYS_REGS-1:0] INIT_MASK =
    {{(PHYS_REGS-ARCH_COUNT){1'b1}}, {ARCH_COUNT{1'b0}}};
  localparam logic [PHYS_REGS-1:0] PR0_BIT = PHYS_REGS'(1);

  logic [PHYS_REGS-1:0]   avail;
  logic [PHYS_REGS-1:0]   avail_next;
  logic [PHYS_REGS-1:0]   granted;
  logic [N-1:0]           sel_valid;
  logic [N*PRW-1:0]       sel_idx;
  logic [N*PHYS_REGS-1:0] sel_onehot;

  free_list_ps_lowest_n #(.W(PHYS_REGS), .N(N)) u_sel (
    .req        (avail & ~PR0_BIT),
    .sel_valid  (sel_valid),
    .sel_idx    (sel_idx),
    .sel_onehot (sel_onehot)
  );

  // Requesting lanes consume selector slots in order; ptr marks the next slot.
  // Because slot validity is monotonic, the first unsatisfied lane starves all later ones.
  always_comb begin
    logic [N-1:0] ptr;
    ptr         = N'(1);
    alloc_valid = '0;
    alloc_tags  = '0;
    granted     = '0;
    for (int i = 0; i < N; i++) begin
      if (alloc_req[i] && !mispredict && !reset) begin
        for (int k = 0; k < N; k++) begin
          if (ptr[k] && sel_valid[k]) begin
            alloc_valid[i]           = 1'b1;
            alloc_tags[i*PRW +: PRW] = sel_idx[k*PRW +: PRW];
            granted                  = granted | sel_onehot[k*PHYS_REGS +: PHYS_REGS];
          end
        end
        ptr = ptr << 1;
      end
    end
  end

  // restore_mask already reflects this cycle's retire frees, so free_mask is dropped.
  always_comb begin
    avail_next = mispredict ? (restore_mask & ~PR0_BIT)
                            : ((avail & ~granted) | (free_mask & ~PR0_BIT));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      avail           <= INIT_MASK;
      double_free_err <= 1'b0;
    end else begin
      avail <= avail_next;
      if (!mispredict && |(free_mask & avail & ~PR0_BIT))
        double_free_err <= 1'b1;
    end
  end

  always_comb begin
    free_count = '0;
    for (int i = 0; i < PHYS_REGS; i++)
      free_count = free_count + CNTW'(avail[i]);
  end

  assign avail_dbg = avail;

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list with N=3, 64 PRs, 32 arch regs; expected
// values are hand-derived from the allocation/free/restore rules.
module tb_free_list;
  import free_list_pkg::*;

  localparam int NL   = 3;
  localparam int PR   = 64;
  localparam int PRW  = 6;
  localparam int CNTW = 7;

  logic              clock = 1'b0;
  logic              reset;
  logic [NL-1:0]     alloc_req;
  logic [NL-1:0]     alloc_valid;
  logic [NL*PRW-1:0] alloc_tags;
  logic [PR-1:0]     free_mask;
  logic              mispredict;
  logic [PR-1:0]     restore_mask;
  logic [CNTW-1:0]   free_count;
  logic [PR-1:0]     avail_dbg;
  logic              double_free_err;

  int tests = 0;
  int fails = 0;
  logic [PR-1:0] init_m;
  logic [PR-1:0] one;

  free_list #(.N(NL), .PHYS_REGS(PR), .ARCH_COUNT(32)) dut (
    .clock           (clock),
    .reset           (reset),
    .alloc_req       (alloc_req),
    .alloc_valid     (alloc_valid),
    .alloc_tags      (alloc_tags),
    .free_mask       (free_mask),
    .mispredict      (mispredict),
    .restore_mask    (restore_mask),
    .free_count      (free_count),
    .avail_dbg       (avail_dbg),
    .double_free_err (double_free_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] tag_of(input int lane);
    return 64'(alloc_tags[lane*PRW +: PRW]);
  endfunction

  initial begin
    init_m = 64'hFFFF_FFFF_0000_0000;
    one    = 64'd1;
    reset = 1'b1; alloc_req = '0; free_mask = '0; mispredict = 1'b0; restore_mask = '0;
    tick(); tick();
    reset = 1'b0;
    settle();
    check("rst_count", 64'(free_count), 64'd32);
    check("rst_err",   64'(double_free_err), 64'd0);
    check("rst_valid", 64'(alloc_valid), 64'd0);
    check("rst_tags",  64'(alloc_tags), 64'd0);
    check("rst_avail", avail_dbg, init_m);
    check("pkg_mask",  INITIAL_AVAIL_MASK, init_m);

    // all three lanes take the three lowest free PRs
    tick(); alloc_req = 3'b111; settle();
    check("t1_valid", 64'(alloc_valid), 64'd7);
    check("t1_tag0", tag_of(0), 64'd32);
    check("t1_tag1", tag_of(1), 64'd33);
    check("t1_tag2", tag_of(2), 64'd34);
    tick(); alloc_req = '0; settle();
    check("t1_count", 64'(free_count), 64'd29);

    // gap lane neither takes nor blocks
    tick(); alloc_req = 3'b101; settle();
    check("t2_valid", 64'(alloc_valid), 64'd5);
    check("t2_tag0", tag_of(0), 64'd35);
    check("t2_tag1", tag_of(1), 64'd0);
    check("t2_tag2", tag_of(2), 64'd36);
    tick();
    for (int i = 0; i < 8; i++) begin
      alloc_req = 3'b111;
      tick();
    end
    alloc_req = 3'b011; tick();
    alloc_req = '0; settle();
    check("t3_count1", 64'(free_count), 64'd1);
    check("t3_avail1", avail_dbg, one << 63);

    // one PR left: lane 0 only
    alloc_req = 3'b111; #1;
    check("t3_valid", 64'(alloc_valid), 64'd1);
    check("t3_tag0", tag_of(0), 64'd63);
    check("t3_tag12", 64'(alloc_tags[2*PRW-1:PRW]) | 64'(alloc_tags[3*PRW-1:2*PRW]), 64'd0);
    tick(); settle();
    check("t3_count0", 64'(free_count), 64'd0);
    check("t3_empty_valid", 64'(alloc_valid), 64'd0);
    check("t3_empty_tags", 64'(alloc_tags), 64'd0);

    // free in cycle t is not allocatable until t+1
    tick(); free_mask = one << 5; settle();
    check("t4_nobypass", 64'(alloc_valid), 64'd0);
    tick(); free_mask = '0; settle();
    check("t4_valid", 64'(alloc_valid), 64'd1);
    check("t4_tag0", tag_of(0), 64'd5);
    tick(); alloc_req = '0; settle();
    check("t4_count", 64'(free_count), 64'd0);
    check("t4_err", 64'(double_free_err), 64'd0);

    // mispredict restore wins over requests and frees
    tick(); mispredict = 1'b1; restore_mask = init_m; alloc_req = 3'b111; free_mask = one << 7; settle();
    check("t5_valid", 64'(alloc_valid), 64'd0);
    tick(); mispredict = 1'b0; restore_mask = '0; alloc_req = '0; free_mask = '0; settle();
    check("t5_avail", avail_dbg, init_m);
    check("t5_count", 64'(free_count), 64'd32);
    check("t5_err", 64'(double_free_err), 64'd0);

    // PR0 free is ignored
    tick(); free_mask = one; settle();
    tick(); free_mask = '0; settle();
    check("pr0_avail", avail_dbg, init_m);
    check("pr0_err", 64'(double_free_err), 64'd0);

    // double free is sticky
    tick(); free_mask = one << 40; settle();
    tick(); free_mask = '0; settle();
    check("t6_err", 64'(double_free_err), 64'd1);
    tick(); tick(); settle();
    check("t6_sticky", 64'(double_free_err), 64'd1);

    // full list: PR0 stays masked, lanes get 1,2,3
    tick(); mispredict = 1'b1; restore_mask = '1; settle();
    tick(); mispredict = 1'b0; restore_mask = '0; settle();
    check("full_count", 64'(free_count), 64'd63);
    tick(); alloc_req = 3'b111; settle();
    check("full_valid", 64'(alloc_valid), 64'd7);
    check("full_tag0", tag_of(0), 64'd1);
    check("full_tag2", tag_of(2), 64'd3);

    // reset overrides everything
    tick(); reset = 1'b1; mispredict = 1'b1; restore_mask = '1; free_mask = one << 40; settle();
    check("rst2_valid", 64'(alloc_valid), 64'd0);
    tick(); reset = 1'b0; mispredict = 1'b0; restore_mask = '0; free_mask = '0; alloc_req = '0; settle();
    check("rst2_avail", avail_dbg, init_m);
    check("rst2_err", 64'(double_free_err), 64'd0);
    check("rst2_count", 64'(free_count), 64'd32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
